// File: rtl/frame_sched_pkg.sv
// Shared constants and helpers for the frame scheduler and its clients
// (game FSM, animation and obstacle-spawn logic).
package frame_sched_pkg;

  // Default clocking: 50 MHz system clock, 60 Hz frame tick.
  localparam int CLK_HZ_DEFAULT  = 50000000;
  localparam int TICK_HZ_DEFAULT = 60;

  // Channel layout shared with the game FSM.
  localparam int NCH_DEFAULT     = 4;
  localparam int SKIP_W_DEFAULT  = 4;
  localparam int FRAME_W_DEFAULT = 16;

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int counter_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/frame_sched_channel.sv
// One frame-skip channel: counts frame ticks down from a reloadable skip
// value, pulses when the count is exhausted, and optionally disarms itself.
module frame_sched_channel
  import frame_sched_pkg::*;
#(
  parameter int SKIP_W = SKIP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrap,
  input  logic [SKIP_W-1:0] skip,
  input  logic              oneshot,
  input  logic              restart,
  output logic              tick,
  output logic [SKIP_W-1:0] count,
  output logic              active
);

  logic [SKIP_W-1:0] count_reg;
  logic [SKIP_W-1:0] count_next;
  logic              active_reg;
  logic              active_next;
  logic              tick_reg;
  logic              tick_next;

  // Next-state selection: restart beats a coincident frame wrap, so the
  // frame that arrives together with a re-arm is not counted.
  always_comb begin
    count_next  = count_reg;
    active_next = active_reg;
    tick_next   = 1'b0;
    if (restart) begin
      count_next  = skip;
      active_next = 1'b1;
    end else if (wrap && active_reg) begin
      if (count_reg == '0) begin
        tick_next  = 1'b1;
        count_next = skip;
        if (oneshot) begin
          active_next = 1'b0;
        end
      end else begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  // State registers; reset loads the skip value presented during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= skip;
      active_reg <= 1'b1;
      tick_reg   <= 1'b0;
    end else begin
      count_reg  <= count_next;
      active_reg <= active_next;
      tick_reg   <= tick_next;
    end
  end

  assign tick   = tick_reg;
  assign count  = count_reg;
  assign active = active_reg;

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: one shared prescaler produces the frame tick and frame
// number; NCH skip channels divide that tick for game-logic consumers.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = TICK_HZ_DEFAULT,
  parameter int DIV     = CLK_HZ / TICK_HZ,
  parameter int DIV_W   = counter_width(DIV),
  parameter int NCH     = NCH_DEFAULT,
  parameter int SKIP_W  = SKIP_W_DEFAULT,
  parameter int FRAME_W = FRAME_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NCH*SKIP_W-1:0] skip,
  input  logic [NCH-1:0]        oneshot,
  input  logic [NCH-1:0]        restart,
  output logic                  frame_tick,
  output logic [FRAME_W-1:0]    frame_num,
  output logic [NCH-1:0]        ch_tick,
  output logic [NCH*SKIP_W-1:0] ch_count,
  output logic [NCH-1:0]        ch_active
);

  localparam logic [DIV_W-1:0] PRESCALE_RELOAD = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]   prescaler_reg;
  logic [DIV_W-1:0]   prescaler_next;
  logic               frame_tick_reg;
  logic [FRAME_W-1:0] frame_num_reg;
  logic [FRAME_W-1:0] frame_num_next;
  logic               wrap;

  // A frame boundary is the enabled cycle on which the prescaler sits at zero.
  assign wrap = enable && (prescaler_reg == '0);

  // Prescaler and frame number advance only while the game is running.
  always_comb begin
    prescaler_next = prescaler_reg;
    frame_num_next = frame_num_reg;
    if (enable) begin
      prescaler_next = wrap ? PRESCALE_RELOAD : prescaler_reg - 1'b1;
    end
    if (wrap) begin
      frame_num_next = frame_num_reg + FRAME_W'(1);
    end
  end

  // Prescaler, registered frame tick and free-running frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_reg  <= PRESCALE_RELOAD;
      frame_tick_reg <= 1'b0;
      frame_num_reg  <= '0;
    end else begin
      prescaler_reg  <= prescaler_next;
      frame_tick_reg <= wrap;
      frame_num_reg  <= frame_num_next;
    end
  end

  assign frame_tick = frame_tick_reg;
  assign frame_num  = frame_num_reg;

  // One countdown channel per skip slot, all driven by the shared wrap.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_channel
      frame_sched_channel #(
        .SKIP_W(SKIP_W)
      ) u_channel (
        .clk    (clk),
        .reset  (reset),
        .wrap   (wrap),
        .skip   (skip[gi*SKIP_W +: SKIP_W]),
        .oneshot(oneshot[gi]),
        .restart(restart[gi]),
        .tick   (ch_tick[gi]),
        .count  (ch_count[gi*SKIP_W +: SKIP_W]),
        .active (ch_active[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler (DIV=10, NCH=4, SKIP_W=4, FRAME_W=4).
// Stimulus is driven on the falling edge; a reference model predicts the
// outputs after the next rising edge and queues them for the monitor.
module tb_frame_scheduler;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NCH     = 4;
  localparam int SKIP_W  = 4;
  localparam int FRAME_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  enable;
  logic [NCH*SKIP_W-1:0] skip;
  logic [NCH-1:0]        oneshot;
  logic [NCH-1:0]        restart;
  logic                  frame_tick;
  logic [FRAME_W-1:0]    frame_num;
  logic [NCH-1:0]        ch_tick;
  logic [NCH*SKIP_W-1:0] ch_count;
  logic [NCH-1:0]        ch_active;

  frame_scheduler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .NCH    (NCH),
    .SKIP_W (SKIP_W),
    .FRAME_W(FRAME_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .skip      (skip),
    .oneshot   (oneshot),
    .restart   (restart),
    .frame_tick(frame_tick),
    .frame_num (frame_num),
    .ch_tick   (ch_tick),
    .ch_count  (ch_count),
    .ch_active (ch_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                  ft;
    logic [FRAME_W-1:0]    fn;
    logic [NCH-1:0]        ct;
    logic [NCH*SKIP_W-1:0] cc;
    logic [NCH-1:0]        ca;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   cycle_no      = 0;

  // Stimulus staging; copied onto the DUT pins at each falling edge.
  logic                  st_reset   = 1'b1;
  logic                  st_enable  = 1'b1;
  logic [NCH*SKIP_W-1:0] st_skip    = '0;
  logic [NCH-1:0]        st_oneshot = '0;

  // Reference model: frames are counted as "enabled cycles since reset",
  // and each channel as "frames seen since its last (re)load".
  int m_enabled = 0;
  int m_frame   = 0;
  int m_load  [NCH];
  int m_since [NCH];
  bit m_act   [NCH];
  bit m_tick  [NCH];
  bit m_ftick   = 0;

  function automatic bit model_wrap_next();
    return !st_reset && st_enable && ((m_enabled % DIV) == DIV - 1);
  endfunction

  task automatic model_step(input logic [NCH-1:0] rs);
    exp_t x;
    bit   wr;
    if (st_reset) begin
      m_enabled = 0;
      m_frame   = 0;
      m_ftick   = 0;
      for (int i = 0; i < NCH; i++) begin
        m_load[i]  = int'(st_skip[i*SKIP_W +: SKIP_W]);
        m_since[i] = 0;
        m_act[i]   = 1;
        m_tick[i]  = 0;
      end
    end else begin
      wr = model_wrap_next();
      if (st_enable) m_enabled++;
      m_ftick = wr;
      if (wr) m_frame = (m_frame + 1) % (1 << FRAME_W);
      for (int i = 0; i < NCH; i++) begin
        m_tick[i] = 0;
        if (rs[i]) begin
          m_load[i]  = int'(st_skip[i*SKIP_W +: SKIP_W]);
          m_since[i] = 0;
          m_act[i]   = 1;
        end else if (wr && m_act[i]) begin
          if (m_since[i] == m_load[i]) begin
            m_tick[i]  = 1;
            m_load[i]  = int'(st_skip[i*SKIP_W +: SKIP_W]);
            m_since[i] = 0;
            if (st_oneshot[i]) m_act[i] = 0;
          end else begin
            m_since[i]++;
          end
        end
      end
    end
    x.ft = m_ftick;
    x.fn = FRAME_W'(m_frame);
    for (int i = 0; i < NCH; i++) begin
      x.ct[i] = m_tick[i];
      x.ca[i] = m_act[i];
      x.cc[i*SKIP_W +: SKIP_W] = SKIP_W'(m_load[i] - m_since[i]);
    end
    exp_q.push_back(x);
  endtask

  // One clock of stimulus: drive on the falling edge, then predict.
  task automatic cyc(input logic [NCH-1:0] rs);
    @(negedge clk);
    reset   = st_reset;
    enable  = st_enable;
    skip    = st_skip;
    oneshot = st_oneshot;
    restart = rs;
    model_step(rs);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks_total++;
    if (got === want) begin
      checks_passed++;
    end else begin
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle_no, got, want);
    end
  endtask

  // Monitor: compare every presented output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_tick", 32'(frame_tick), 32'(e.ft));
        chk("frame_num",  32'(frame_num),  32'(e.fn));
        chk("ch_tick",    32'(ch_tick),    32'(e.ct));
        chk("ch_count",   32'(ch_count),   32'(e.cc));
        chk("ch_active",  32'(ch_active),  32'(e.ca));
        if (e.ft) begin
          $display("cycle=%0d frame=%0d ch_tick=%b ch_count=%h ch_active=%b",
                   cycle_no, frame_num, ch_tick, ch_count, ch_active);
        end
      end
    end
  end

  // Stimulus: directed test-plan scenarios, then randomized traffic.
  initial begin
    logic [NCH-1:0] rs;
    int             guard;
    reset   = 1'b1;
    enable  = 1'b0;
    skip    = '0;
    oneshot = '0;
    restart = '0;

    // Reset with skip = {3,2,1,0}; channel 2 is one-shot.
    st_reset   = 1'b1;
    st_enable  = 1'b1;
    st_skip    = 16'h3210;
    st_oneshot = 4'b0100;
    repeat (3) cyc('0);
    st_reset = 1'b0;

    // Two frames, then a 25-cycle pause before frame 3.
    repeat (25) cyc('0);
    st_enable = 1'b0;
    repeat (25) cyc('0);
    st_enable = 1'b1;
    repeat (40) cyc('0);

    // Re-arm the spent one-shot channel 2.
    cyc(4'b0100);
    repeat (45) cyc('0);

    // Restart channel 1 exactly on a frame wrap.
    guard = 0;
    while (!model_wrap_next() && guard < 2 * DIV) begin
      cyc('0);
      guard++;
    end
    cyc(4'b0010);

    // Lengthen channel 0's period; the running countdown must finish first.
    st_skip[3:0] = 4'd5;
    repeat (150) cyc('0);

    // Reset in the middle of a frame.
    repeat (4) cyc('0);
    st_reset = 1'b1;
    cyc('0);
    st_reset = 1'b0;
    repeat (30) cyc('0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) st_skip[$urandom_range(0, NCH-1)*SKIP_W +: SKIP_W] = SKIP_W'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) st_oneshot = NCH'($urandom);
      if ($urandom_range(0, 59) == 0) st_enable = ~st_enable;
      if (!st_enable && $urandom_range(0, 9) == 0) st_enable = 1'b1;
      st_reset = ($urandom_range(0, 599) == 0);
      rs = '0;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 79) == 0) rs[i] = 1'b1;
      end
      if (model_wrap_next() && $urandom_range(0, 3) == 0) rs[$urandom_range(0, NCH-1)] = 1'b1;
      cyc(rs);
    end
    st_reset = 1'b0;
    repeat (5) cyc('0);

    // Let the monitor drain, bounded.
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
